// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed / round-robin search and a valid/ready handshake.
// Optional zero-request counter (miss_cnt) is enabled by defining PRIO_ENC_STATS_EN.
module prio_encoder_rr #(
    parameter  int WIDTH = 8,
    localparam int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    output logic [POS_W-1:0] pos,
    output logic             found,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PRIO_ENC_STATS_EN
    ,
    output logic [15:0]      miss_cnt
`endif
);

    logic [POS_W-1:0] r_ptr;
    logic [POS_W-1:0] r_pos;
    logic             r_found;
    logic             r_valid;

    logic             w_accept;
    logic [WIDTH-1:0] w_hi_req;
    logic [POS_W-1:0] w_pos_new;
    logic             w_found_new;
    logic [POS_W-1:0] w_ptr_next;

    function automatic logic [POS_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        lowest_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = POS_W'(i);
        end
    endfunction

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Round-robin: requests at or above the pointer win first; if none, the
    // lowest request overall wins, which is the wrap back through index 0.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_hi_req = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hi_req[i] = din[i] && mode && (i >= int'(r_ptr));
        end
    end

    assign w_found_new = |din;
    assign w_pos_new   = (|w_hi_req) ? lowest_idx(w_hi_req) : lowest_idx(din);
    assign w_ptr_next  = (w_pos_new == POS_W'(WIDTH - 1)) ? '0 : w_pos_new + POS_W'(1);

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // and every state register, outputs included, is cleared by it.
        if (!resetn) begin
            r_ptr   <= '0;
            r_pos   <= '0;
            r_found <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (w_accept) begin
                r_pos   <= w_pos_new;
                r_found <= w_found_new;
                r_valid <= 1'b1;
                if (mode && w_found_new) r_ptr <= w_ptr_next;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pos       = r_pos;
    assign found     = r_found;
    assign out_valid = r_valid;

`ifdef PRIO_ENC_STATS_EN
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_miss_cnt <= '0;
        end else if (w_accept && !w_found_new && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the 4-bit combinational priority encoder.
- Accepts request vectors over a valid/ready handshake and returns one registered result per accepted word: the index of the winning set bit plus a found flag.
- Two selectable modes:
  - fixed priority, where the lowest index wins;
  - round-robin, where the search starts at a rotating pointer.
- Sits between request producers and a downstream grant/dispatch stage.

Parameters:
- WIDTH, 8, number of request bits; legal range 2..64, power of two not required.
- POS_W, $clog2(WIDTH), width of the pos output; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- din  input  WIDTH  request vector
- in_valid  input  1  din is valid this cycle
- in_ready  output  1  block can accept din this cycle
- mode  input  1  0 = fixed (lowest index wins), 1 = round-robin; sampled with din on accept
- pos  output  POS_W  winning bit index
- found  output  1  1 if the accepted din had any bit set
- out_valid  output  1  pos/found hold a result
- out_ready  input  1  downstream consumes the result

Behaviour:
- Reset, synchronous, resetn=0 at a clk edge:
  - out_valid=0, pos=0, found=0, internal rr pointer ptr=0.
  - Any in-flight result is discarded.
  - in_ready is 1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready at a clk edge.
  - On accept: pos/found load the new result and out_valid=1 on the next cycle. Latency is 1 cycle.
  - If out_valid && out_ready and there is no accept, out_valid goes to 0; pos/found keep their last values.
  - If out_valid && !out_ready, pos/found/out_valid are held stable and in_ready=0.
  - Simultaneous consume and accept: the new result replaces the old one with no bubble, so full throughput is 1 word/cycle.
- Fixed mode (mode=0): pos = index of the lowest set bit of din.
- Round-robin mode (mode=1):
  - Search indices ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1; first set bit wins.
  - Wrap is mod WIDTH, including non-power-of-two WIDTH; index WIDTH-1 is followed by 0.
- Pointer update, on accept only:
  - If mode=1 and found: ptr <= (pos_new + 1) mod WIDTH.
  - Otherwise ptr is unchanged. Fixed-mode traffic never moves ptr.
- din == 0: found=0, pos=0, ptr unchanged. Matches the legacy encoder's zero case.
- A mode change takes effect from the next accepted word. No flush and no ptr reset.
- in_valid while in_ready=0: din is not sampled. The producer must hold it.
- X on din with in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro: PRIO_ENC_STATS_EN
- Defined:
  - Adds output miss_cnt, 16 bits.
  - Counts accepted words with din==0.
  - Increments in the same cycle the result registers load.
  - Saturates at 16'hFFFF.
  - Reset value 0 on resetn=0.
- Undefined: the miss_cnt port and its counter are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4, mode=0, out_ready=1, din 0..15 one per cycle -> pos follows 0,0,1,0,2,0,1,0,3,0,1,0,2,0,1,0 one cycle late; found=0 only for din=0.
- WIDTH=4, mode=1, din=4'b1111 accepted four times -> pos 0,1,2,3, then a fifth accept gives 0 (wrap); ptr ends at 1.
- WIDTH=5, mode=1, preset ptr to 4 via din=5'b01000 (pos=3), then din=5'b00011 -> pos=0 (searches 4 then wraps to 0); next din=5'b00011 -> pos=1.
- Backpressure: out_ready=0 after one accept of din=8'h80 -> pos=7, out_valid held, in_ready=0; raising out_ready with a new din=8'h06 accepted in the same cycle -> next cycle pos=1 with no bubble.
- Reset mid-operation: ptr=3, out_valid=1, assert resetn=0 for one edge -> out_valid=0, pos=0, found=0; then mode=1 with din=8'hFF -> pos=0.
- With PRIO_ENC_STATS_EN: accept din=0 three times and din=1 once -> miss_cnt=3; force 65537 zero words -> miss_cnt stays at 16'hFFFF.
